// File: rtl/alu_flag_stage.sv
// Result/flag register stage behind the ALU prefix adder: decodes SLT/SLTU/branch
// outcomes at capture and holds up to two entries so back-pressure never drops data.
module alu_flag_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_sum,
    input  logic             in_carry_out,
    input  logic             in_overflow,
    input  logic             in_negative,
    input  logic             in_zero,
    input  logic [1:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [4:0]       out_rd,
    output logic             out_branch_taken,
    output logic             out_illegal,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] taken_count
);

    // state | meaning
    // EMPTY | no entry held, out_valid low
    // ONE   | head holds the only entry
    // FULL  | head and skid both hold entries, in_ready low
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [4:0]  rd;
        logic        taken;
        logic        illegal;
    } entry_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t new_entry;
    logic   lt;
    logic   ltu;
    logic   accept;
    logic   drain;

    // Adder performs a + ~b + 1 for compares, so carry_out set means a >= b unsigned.
    assign lt  = in_negative ^ in_overflow;
    assign ltu = ~in_carry_out;

    always_comb begin
        new_entry         = '0;
        new_entry.flags   = {in_negative, in_zero, in_carry_out, in_overflow};
        new_entry.rd      = in_rd;
        new_entry.taken   = 1'b0;
        new_entry.illegal = 1'b0;
        case (in_kind)
            2'b00:   new_entry.result = in_sum;
            2'b01:   new_entry.result = {31'b0, lt};
            2'b10:   new_entry.result = {31'b0, ltu};
            default: begin
                new_entry.result = in_sum;
                case (in_funct3)
                    3'b000:  new_entry.taken = in_zero;
                    3'b001:  new_entry.taken = ~in_zero;
                    3'b100:  new_entry.taken = lt;
                    3'b101:  new_entry.taken = ~lt;
                    3'b110:  new_entry.taken = ltu;
                    3'b111:  new_entry.taken = ~ltu;
                    default: new_entry.illegal = 1'b1;
                endcase
            end
        endcase
    end

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            head        <= '0;
            skid        <= '0;
            in_ready    <= 1'b0;
            taken_count <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        head  <= new_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, drain})
                        2'b10: begin
                            skid     <= new_entry;
                            state    <= FULL;
                            in_ready <= 1'b0;
                        end
                        2'b01: begin
                            state    <= EMPTY;
                            in_ready <= 1'b1;
                        end
                        2'b11: begin
                            head     <= new_entry;
                            in_ready <= 1'b1;
                        end
                        default: in_ready <= 1'b1;
                    endcase
                end
                FULL: begin
                    if (drain) begin
                        head     <= skid;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b0;
                end
            endcase

            if (cnt_clear)
                taken_count <= '0;
            else if (drain && head.taken && !(&taken_count))
                taken_count <= taken_count + CNT_W'(1);
        end
    end

    assign out_valid        = (state != EMPTY);
    assign out_result       = head.result;
    assign out_flags        = head.flags;
    assign out_rd           = head.rd;
    assign out_branch_taken = head.taken;
    assign out_illegal      = head.illegal;

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Pipeline register stage directly downstream of the 32-bit prefix adder in the RISC-V ALU.
- Captures the adder's sum and flags (carry_out, overflow, negative, zero) under a valid/ready handshake.
- Derives SLT/SLTU results and branch-taken decisions, and buffers up to two results in a skid buffer so back-pressure never drops data.
- Also keeps a saturating count of delivered taken branches for performance debug.

Parameters:
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has a valid adder result this cycle.
- in_ready  out  1  stage can accept; a transfer occurs when in_valid & in_ready.
- in_sum  in  32  adder sum.
- in_carry_out  in  1  adder carry_out.
- in_overflow  in  1  adder overflow.
- in_negative  in  1  adder negative.
- in_zero  in  1  adder zero.
- in_kind  in  2  00 ADD/SUB, 01 SLT, 10 SLTU, 11 BRANCH.
- in_funct3  in  3  branch condition; used only when in_kind=11.
- in_rd  in  5  destination register tag, passed through unchanged.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- out_result  out  32  final result.
- out_flags  out  4  {N,Z,C,V} of the head entry.
- out_rd  out  5  tag of the head entry.
- out_branch_taken  out  1  branch decision of the head entry.
- out_illegal  out  1  BRANCH entry with an unsupported funct3.
- cnt_clear  in  1  synchronous clear of the taken counter.
- taken_count  out  CNT_W  saturating count of delivered taken branches.

Behaviour:
- Decode is applied at capture (combinational on the in_* signals); the decoded fields are stored per entry.
- Let lt = in_negative ^ in_overflow and ltu = ~in_carry_out. The upstream adder computes a + ~b + 1 for SLT/SLTU/BRANCH.
- out_result by in_kind:
  - 00: in_sum.
  - 01: {31'b0, lt}.
  - 10: {31'b0, ltu}.
  - 11: in_sum.
- Branch taken (in_kind=11) by in_funct3:
  - 000 BEQ: Z.
  - 001 BNE: ~Z.
  - 100 BLT: lt.
  - 101 BGE: ~lt.
  - 110 BLTU: ltu.
  - 111 BGEU: ~ltu.
  - 010 or 011: taken=0 and illegal=1.
- For in_kind other than 11, taken=0 and illegal=0.
- Storage is a 2-entry in-order buffer (head, skid) with count 0/1/2. States are EMPTY, ONE, FULL.
  - EMPTY: accept → ONE.
  - ONE: accept with no drain → FULL; drain with no accept → EMPTY; accept and drain together → ONE, and the new entry becomes head.
  - FULL: drain → ONE, and skid moves to head. No accept is possible in FULL.
- out_valid = (count != 0). All out_* fields come from the head entry and are held stable while out_valid & ~out_ready.
- in_ready is registered and equals (next count != 2).
- Latency: an accepted entry appears on out_* in the cycle after acceptance when the buffer was EMPTY, or when it was ONE and drained in the same cycle. Throughput is 1 per cycle when out_ready is held high.
- taken_count:
  - Increments by 1 on each output transfer with out_branch_taken=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clear forces it to 0 and has priority over an increment in the same cycle.
- Reset, asynchronous and legal mid-transfer: count=0, out_valid=0, in_ready=0, out_result=0, out_flags=0, out_rd=0, out_branch_taken=0, out_illegal=0, taken_count=0. Buffered entries are discarded. in_ready rises on the first clk edge after reset deasserts.
- Inputs are ignored whenever in_ready=0. Upstream must hold its data while in_valid & ~in_ready.

Test Plan:
1. Reset then single ADD: in_sum=0x0000_1234, kind=00, rd=5, out_ready=1 → next cycle out_valid=1, out_result=0x1234, out_rd=5, taken=0; following cycle out_valid=0.
2. SLT/SLTU, 5 − 7: sum=0xFFFF_FFFE, N=1, V=0, C=0.
   - kind=01 → out_result=1.
   - kind=10 → out_result=1.
   - With C=1, kind=10 → out_result=0.
3. Branch sweep with Z=1, C=1, N=0, V=0:
   - funct3=000 → taken=1; 001 → 0; 100 → 0; 101 → 1; 110 → 0; 111 → 1.
   - funct3=010 → taken=0, out_illegal=1.
4. Back-pressure: out_ready=0 while feeding A, B, C back-to-back.
   - A and B are accepted; in_ready drops after B; C is held.
   - Raise out_ready → outputs A, B, C in order, no loss or duplication, one per cycle.
5. Counter: deliver 3 taken BEQ and 1 not-taken → taken_count=3. Assert cnt_clear together with a taken transfer → 0. With CNT_W=2, 5 taken → 3.
6. Reset asserted asynchronously while FULL with out_ready=0 → all outputs 0 immediately. After deassert, no stale entry ever appears and in_ready=1 after one edge.
